inst_issue_buffer: RTL and testbench

Decoded-instruction FIFO between the instruction fetch/decode stage and the dispatch/issue logic of the speculative out-of-order core. Each cycle it captures the decoded fields (opcode, register specifiers, immediate, jump address, PC) that fetch/decode presents, and holds them until dispatch accepts them. It backpressures fetch when full, and discards all buffered work on a misprediction flush. It also tracks the end-of-program condition that fetch signals.

---
 rtl/inst_issue_buffer.sv | 122 ++++++++++++
 tb/tb_inst_issue_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_issue_buffer.sv
// Decoded-instruction FIFO between fetch/decode and dispatch, first-word-fall-through.
// Optional same-cycle bypass on an empty buffer when IBUF_BYPASS_EN is defined.
module inst_issue_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      in_opcode,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [15:0]      in_immediate,
  input  logic [25:0]      in_address,
  input  logic [31:0]      in_pc,
  input  logic             in_valid,
  input  logic             in_end,
  input  logic             flush,
  input  logic             issue_ready,
  output logic [11:0]      out_opcode,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [15:0]      out_immediate,
  output logic [25:0]      out_address,
  output logic [31:0]      out_pc,
  output logic             out_valid,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = 12 + 5 * 4 + 16 + 26 + 32;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               end_seen_r;

  logic [ENTRY_W-1:0] in_entry_s;
  logic [ENTRY_W-1:0] head_s;
  logic               empty_s;
  logic               full_s;
  logic               bypass_s;
  logic               enq_s;
  logic               deq_s;

  assign in_entry_s = {in_opcode, in_rs, in_rt, in_rd, in_shamt,
                       in_immediate, in_address, in_pc};
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign full_s     = (count_r == DEPTH_C);

`ifdef IBUF_BYPASS_EN
  assign bypass_s = empty_s && in_valid && issue_ready && !flush;
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed instruction is consumed directly and never occupies a slot.
  assign enq_s = in_valid && !full_s && !flush && !bypass_s;
  assign deq_s = !empty_s && issue_ready && !flush;

  // Head selection: stored entry, or the live input while bypassing.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (bypass_s) begin
      head_s = in_entry_s;
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
  end

  assign {out_opcode, out_rs, out_rt, out_rd, out_shamt,
          out_immediate, out_address, out_pc} = head_s;
  assign out_valid = !empty_s || bypass_s;
  assign full      = full_s;
  assign count     = count_r;
  assign done      = end_seen_r && empty_s;

  // Entry storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_r[wr_ptr_r] <= in_entry_s;
    end
  end

  // Pointers, occupancy and sticky end-of-program flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      end_seen_r <= 1'b0;
    end else if (flush) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      end_seen_r <= 1'b0;
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (in_end) begin
        end_seen_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_issue_buffer.sv
// Self-checking bench for inst_issue_buffer: directed scenarios then random traffic
// against a queue-based reference model.
module tb_inst_issue_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [11:0] opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [31:0] pc;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [11:0]      in_opcode;
  logic [4:0]       in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]      in_immediate;
  logic [25:0]      in_address;
  logic [31:0]      in_pc;
  logic             in_valid, in_end, flush, issue_ready;
  logic [11:0]      out_opcode;
  logic [4:0]       out_rs, out_rt, out_rd, out_shamt;
  logic [15:0]      out_immediate;
  logic [25:0]      out_address;
  logic [31:0]      out_pc;
  logic             out_valid, full, done;
  logic [CNT_W-1:0] count;

  inst_issue_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_immediate(in_immediate), .in_address(in_address),
    .in_pc(in_pc), .in_valid(in_valid), .in_end(in_end), .flush(flush),
    .issue_ready(issue_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_immediate(out_immediate), .out_address(out_address),
    .out_pc(out_pc), .out_valid(out_valid), .full(full), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  int     vectors = 0;
  int     miscompares = 0;
  entry_t q[$];
  bit     end_seen = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t cur_in();
    entry_t e;
    e.opcode = in_opcode; e.rs = in_rs; e.rt = in_rt; e.rd = in_rd;
    e.shamt = in_shamt; e.imm = in_immediate; e.addr = in_address; e.pc = in_pc;
    return e;
  endfunction

  // Compare all outputs against the model given the current state and live inputs.
  task automatic check_all();
    bit     byp;
    entry_t exp_head;
    entry_t obs_head;
    byp = BYP && (q.size() == 0) && in_valid && issue_ready && !flush;
    chk("out_valid", 128'(out_valid), 128'((q.size() != 0) || byp));
    chk("count", 128'(count), 128'(q.size()));
    chk("full", 128'(full), 128'(q.size() == DEPTH));
    chk("done", 128'(done), 128'(end_seen && (q.size() == 0)));
    if (q.size() != 0 || byp) begin
      exp_head = (q.size() != 0) ? q[0] : cur_in();
      obs_head = {out_opcode, out_rs, out_rt, out_rd, out_shamt,
                  out_immediate, out_address, out_pc};
      chk("head", 128'(obs_head), 128'(exp_head));
    end
  endtask

  // Advance the model by one posedge using the currently applied inputs.
  task automatic model_update();
    bit byp, was_full;
    if (flush) begin
      q.delete();
      end_seen = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      byp = BYP && (q.size() == 0) && in_valid && issue_ready;
      if (q.size() != 0 && issue_ready) void'(q.pop_front());
      if (in_valid && !was_full && !byp) q.push_back(cur_in());
      if (in_end) end_seen = 1'b1;
    end
  endtask

  // Called at a negedge: apply inputs, check, step model and DUT, return at next negedge.
  task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                      input logic fl, input logic en);
    in_valid = v; in_pc = pc; issue_ready = rdy; flush = fl; in_end = en;
    in_opcode = 12'($urandom); in_rs = 5'($urandom); in_rt = 5'($urandom);
    in_rd = 5'($urandom); in_shamt = 5'($urandom);
    in_immediate = 16'($urandom); in_address = 26'($urandom);
    #1;
    check_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_count", 128'(count), 128'(0));
    chk("async_rst_valid", 128'(out_valid), 128'(0));
    q.delete();
    end_seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_end = 1'b0; flush = 1'b0; issue_ready = 1'b0;
    in_opcode = 12'h000; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
    in_immediate = 16'h0000; in_address = 26'h0; in_pc = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 128'(out_valid), 128'(0));
    chk("reset_full", 128'(full), 128'(0));
    chk("reset_count", 128'(count), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    rst = 1'b0;

    // Single enqueue with fixed fields
    in_valid = 1'b1; in_pc = 32'h4; issue_ready = 1'b0; flush = 1'b0; in_end = 1'b0;
    in_opcode = 12'h020; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
    #1;
    check_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("single_valid", 128'(out_valid), 128'(1));
    chk("single_pc", 128'(out_pc), 128'(32'h4));
    chk("single_opcode", 128'(out_opcode), 128'(12'h020));
    chk("single_rd", 128'(out_rd), 128'(5'd3));
    chk("single_count", 128'(count), 128'(1));

    // Fill to full; fifth enqueue is dropped; drain in order
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 128'(full), 128'(1));
    chk("fill_count", 128'(count), 128'(4));
    step(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
    chk("drop_count", 128'(count), 128'(4));
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 128'(out_pc), 128'(i * 4));
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_count", 128'(count), 128'(0));

    // Full with simultaneous valid and ready: dequeue only
    for (int i = 0; i < 4; i++) step(1'b1, 32'(32'h40 + i * 4), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h50, 1'b1, 1'b0, 1'b0);
    chk("fullrw_count", 128'(count), 128'(3));
    chk("fullrw_full", 128'(full), 128'(0));
    chk("fullrw_head", 128'(out_pc), 128'(32'h44));
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Pointer wrap at steady occupancy of 2
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'(32'h108 + i * 4), 1'b1, 1'b0, 1'b0);
    chk("wrap_count", 128'(count), 128'(2));
    chk("wrap_head", 128'(out_pc), 128'(32'h128));

    // Flush with 3 entries while a new instruction is offered
    step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_valid", 128'(out_valid), 128'(0));
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_stay_empty", 128'(count), 128'(0));

    // End-of-program tracking
    step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("end_done0", 128'(done), 128'(0));
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("end_done1", 128'(done), 128'(0));
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("end_done2", 128'(done), 128'(1));
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("end_flush_done", 128'(done), 128'(0));

    // Empty buffer with valid and ready (bypass case when enabled)
    step(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    chk("empty_vr_count", 128'(count), 128'(BYP ? 0 : 1));
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random traffic with one asynchronous reset mid-run
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      step(1'b1 & ($urandom_range(3) != 0), $urandom, 1'($urandom),
           1'($urandom_range(15) == 0), 1'($urandom_range(31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
